// File: rtl/dpwm_duty_scheduler.sv
// dpwm_duty_scheduler
// Sequences the duty command into the 6-bit DPWM comparator (d_n_out).
// Requests arrive over valid/ready and are clamped to [D_MIN, D_MAX].
// A soft-start ramp runs after enable. New duty values are committed only on
// the sync pulse (counter wrap), so the threshold never changes mid-period.
// A fault forces duty to zero.
// Optional feature macro: DUTY_SLEW_LIMIT_EN. When it is defined, each RUN
// commit moves the duty toward the pending value by at most MAX_STEP.
module dpwm_duty_scheduler #(
  parameter int DW       = 6,
  parameter int D_MIN    = 2,
  parameter int D_MAX    = 58,
  parameter int SS_STEP  = 1,
  parameter int MAX_STEP = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sync,
  input  logic          fault,
  input  logic          req_valid,
  input  logic [DW-1:0] req_duty,
  output logic          req_ready,
  output logic [DW-1:0] d_n_out,
  output logic [1:0]    state,
  output logic          ss_done,
  output logic          clamp_flag
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SOFT  = 2'b01,
    ST_RUN   = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

`ifdef DUTY_SLEW_LIMIT_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  // Without the slew limit the step bound exceeds any possible duty difference,
  // so every commit lands directly on the pending value.
  localparam int              STEP_LIM = SLEW_EN ? MAX_STEP : (1 << DW);
  localparam logic [DW:0]     L_STEP   = (DW+1)'(STEP_LIM);
  localparam logic [DW:0]     L_SS     = (DW+1)'(SS_STEP);
  localparam logic [DW-1:0]   L_DMIN   = DW'(D_MIN);
  localparam logic [DW-1:0]   L_DMAX   = DW'(D_MAX);

  function automatic logic [DW-1:0] f_clamp(input logic [DW-1:0] v);
    if (v < L_DMIN)      return L_DMIN;
    else if (v > L_DMAX) return L_DMAX;
    else                 return v;
  endfunction

  function automatic logic f_outside(input logic [DW-1:0] v);
    return (v < L_DMIN) || (v > L_DMAX);
  endfunction

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_d_n, w_d_nxt;
  logic [DW-1:0] r_target, w_target_nxt;
  logic [DW-1:0] r_pend, w_pend_nxt;
  logic          r_pend_v, w_pend_v_nxt;
  logic          r_clamp, w_clamp_nxt;
  logic          r_ss_done, w_ss_done_nxt;

  logic          w_xfer;
  logic [DW-1:0] w_clamped;
  logic [DW:0]   w_sum;
  logic [DW-1:0] w_ramp;
  logic          w_up;
  logic [DW-1:0] w_diff;
  logic [DW-1:0] w_commit;
  logic          w_commit_done;

  assign w_xfer    = req_valid & req_ready;
  assign w_clamped = f_clamp(req_duty);
  assign w_sum     = {1'b0, r_d_n} + L_SS;

  // Ready: open in SOFT, open in RUN only when the single pending slot is free.
  always_comb begin
    req_ready = 1'b0;
    case (r_state)
      ST_SOFT: req_ready = 1'b1;
      ST_RUN:  req_ready = ~r_pend_v;
      default: req_ready = 1'b0;
    endcase
  end

  // Soft-start ramp value: one step up, never past target (no wrap at DW+1 bits).
  always_comb begin
    w_ramp = r_target;
    if (w_sum > {1'b0, r_target}) begin
      w_ramp = r_target;
    end else begin
      w_ramp = w_sum[DW-1:0];
    end
  end

  // RUN commit value toward pending, limited to STEP_LIM per period.
  always_comb begin
    w_up          = (r_pend > r_d_n);
    w_diff        = w_up ? (r_pend - r_d_n) : (r_d_n - r_pend);
    w_commit      = r_pend;
    w_commit_done = 1'b1;
    if ({1'b0, w_diff} > L_STEP) begin
      w_commit      = w_up ? (r_d_n + L_STEP[DW-1:0]) : (r_d_n - L_STEP[DW-1:0]);
      w_commit_done = 1'b0;
    end else begin
      w_commit      = r_pend;
      w_commit_done = 1'b1;
    end
  end

  // Next-state logic: fault > en deassert > sync commit > request capture.
  always_comb begin
    w_state_nxt  = r_state;
    w_d_nxt      = r_d_n;
    w_target_nxt = r_target;
    w_pend_nxt   = r_pend;
    w_pend_v_nxt = r_pend_v;
    w_clamp_nxt  = w_xfer & f_outside(req_duty);
    if (fault && (r_state != ST_FAULT)) begin
      w_state_nxt  = ST_FAULT;
      w_d_nxt      = '0;
      w_pend_v_nxt = 1'b0;
      w_target_nxt = L_DMIN;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (sync && en) begin
            w_state_nxt = ST_SOFT;
            w_d_nxt     = L_DMIN;
          end else begin
            w_d_nxt     = '0;
          end
        end
        ST_SOFT: begin
          if (w_xfer) begin
            w_target_nxt = w_clamped;
          end else begin
            w_target_nxt = r_target;
          end
          if (sync && !en) begin
            w_state_nxt  = ST_IDLE;
            w_d_nxt      = '0;
            w_pend_v_nxt = 1'b0;
          end else if (sync) begin
            w_d_nxt = w_ramp;
            if (w_ramp == r_target) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_state_nxt = ST_SOFT;
            end
          end else begin
            w_d_nxt = r_d_n;
          end
        end
        ST_RUN: begin
          if (sync && !en) begin
            w_state_nxt  = ST_IDLE;
            w_d_nxt      = '0;
            w_pend_v_nxt = 1'b0;
          end else if (sync && r_pend_v) begin
            w_d_nxt      = w_commit;
            w_pend_v_nxt = ~w_commit_done;
          end else if (w_xfer) begin
            w_pend_nxt   = w_clamped;
            w_pend_v_nxt = 1'b1;
          end else begin
            w_pend_v_nxt = r_pend_v;
          end
        end
        ST_FAULT: begin
          w_d_nxt = '0;
          if (!fault && !en) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_FAULT;
          end
        end
        default: begin
          w_state_nxt  = ST_FAULT;
          w_d_nxt      = '0;
          w_pend_v_nxt = 1'b0;
          w_target_nxt = L_DMIN;
        end
      endcase
    end
    w_ss_done_nxt = (w_state_nxt == ST_RUN);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_d_n     <= '0;
      r_target  <= L_DMIN;
      r_pend    <= '0;
      r_pend_v  <= 1'b0;
      r_clamp   <= 1'b0;
      r_ss_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_d_n     <= w_d_nxt;
      r_target  <= w_target_nxt;
      r_pend    <= w_pend_nxt;
      r_pend_v  <= w_pend_v_nxt;
      r_clamp   <= w_clamp_nxt;
      r_ss_done <= w_ss_done_nxt;
    end
  end

  assign d_n_out    = r_d_n;
  assign state      = r_state;
  assign ss_done    = r_ss_done;
  assign clamp_flag = r_clamp;

endmodule

// File: tb/tb_dpwm_duty_scheduler.sv
// Self-checking bench for dpwm_duty_scheduler: directed scenarios pinned with
// hand-computed values, then randomized traffic checked every cycle against a
// behavioural model (integers plus a pending queue).
module tb_dpwm_duty_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic       fault = 1'b0;
  logic       req_valid = 1'b0;
  logic [5:0] req_duty = 6'd0;
  logic       req_ready;
  logic [5:0] d_n_out;
  logic [1:0] state;
  logic       ss_done;
  logic       clamp_flag;

  int checks = 0;
  int failures = 0;

  dpwm_duty_scheduler dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .fault(fault),
    .req_valid(req_valid), .req_duty(req_duty), .req_ready(req_ready),
    .d_n_out(d_n_out), .state(state), .ss_done(ss_done), .clamp_flag(clamp_flag)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 soft-start, 2 run, 3 fault
  int  m_mode, m_d, m_tgt;
  int  m_pq[$];
  bit  m_clamp, m_ok = 1'b0, m_last_xfer = 1'b0;
  int  mv_c, mv_p, mv_delta;
  bit  mv_xf, mv_out;

  function automatic bit m_ready();
    return (m_mode == 1) || (m_mode == 2 && m_pq.size() == 0);
  endfunction

  always @(posedge clk) begin
    mv_xf  = req_valid && m_ok && m_ready();
    mv_out = (req_duty < 2) || (req_duty > 58);
    mv_c   = (req_duty < 2) ? 2 : ((req_duty > 58) ? 58 : int'(req_duty));
    if (rst) begin
      m_mode = 0; m_d = 0; m_tgt = 2; m_pq.delete(); m_clamp = 0; m_ok = 1; mv_xf = 0;
    end else if (m_ok) begin
      m_clamp = mv_xf && mv_out;
      if (fault && m_mode != 3) begin
        m_mode = 3; m_d = 0; m_tgt = 2; m_pq.delete();
      end else if (m_mode == 0) begin
        if (sync && en) begin m_mode = 1; m_d = 2; end
      end else if (m_mode == 1) begin
        if (sync && !en) begin
          m_mode = 0; m_d = 0;
        end else if (sync) begin
          m_d = (m_d + 1 < m_tgt) ? m_d + 1 : m_tgt;
          if (m_d == m_tgt) m_mode = 2;
        end
        if (mv_xf) m_tgt = mv_c;
      end else if (m_mode == 2) begin
        if (sync && !en) begin
          m_mode = 0; m_d = 0; m_pq.delete();
        end else if (sync && m_pq.size() != 0) begin
          mv_p = m_pq[0];
          mv_delta = mv_p - m_d;
`ifdef DUTY_SLEW_LIMIT_EN
          if (mv_delta > 4) m_d = m_d + 4;
          else if (mv_delta < -4) m_d = m_d - 4;
          else begin m_d = mv_p; void'(m_pq.pop_front()); end
`else
          m_d = mv_p; void'(m_pq.pop_front());
`endif
        end else if (mv_xf) begin
          m_pq.push_back(mv_c);
        end
      end else begin
        if (!fault && !en) m_mode = 0;
      end
    end
    m_last_xfer = mv_xf;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  bit auto_sync = 1'b1;
  int scnt = 0;
  bit edge_sync = 1'b0;

  // One clock: advance, compare every output to the model, set next sync.
  task automatic cyc();
    logic s;
    s = sync;
    @(posedge clk);
    #1;
    edge_sync = s;
    if (m_ok) begin
      chk("model_d_n_out", {2'b00, d_n_out}, 8'(m_d));
      chk("model_state", {6'd0, state}, 8'(m_mode));
      chk("model_ss_done", {7'd0, ss_done}, {7'd0, (m_mode == 2)});
      chk("model_clamp_flag", {7'd0, clamp_flag}, {7'd0, m_clamp});
      chk("model_req_ready", {7'd0, req_ready}, {7'd0, m_ready()});
    end
    if (auto_sync) begin
      sync = (scnt == 63);
      scnt = (scnt + 1) % 64;
    end else begin
      sync = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic wait_sync();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (edge_sync) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL wait_sync timeout at %0t", $time);
    end
  endtask

  task automatic send(input int v);
    req_valid = 1'b1;
    req_duty  = 6'(v);
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 40; i++) begin
      if (m_pq.size() == 0) break;
      wait_sync();
    end
  endtask

  initial begin
    // Reset values
    repeat (3) cyc();
    chk("rst_state", {6'd0, state}, 8'd0);
    chk("rst_d", {2'b00, d_n_out}, 8'd0);
    chk("rst_ready", {7'd0, req_ready}, 8'd0);
    chk("rst_ss_done", {7'd0, ss_done}, 8'd0);
    rst = 1'b0;
    en  = 1'b1;

    // Soft-start with no request: one period in SOFT at D_MIN
    wait_sync();
    chk("ss_first_state", {6'd0, state}, 8'd1);
    chk("ss_first_d", {2'b00, d_n_out}, 8'd2);
    wait_sync();
    chk("ss_second_state", {6'd0, state}, 8'd2);
    chk("ss_second_done", {7'd0, ss_done}, 8'd1);
    chk("ss_second_d", {2'b00, d_n_out}, 8'd2);

    // Disable, re-enable, ramp to 10
    en = 1'b0;
    wait_sync();
    chk("dis_state", {6'd0, state}, 8'd0);
    en = 1'b1;
    wait_sync();
    send(10);
    repeat (8) wait_sync();
    chk("ramp_state", {6'd0, state}, 8'd2);
    chk("ramp_d", {2'b00, d_n_out}, 8'd10);

    // Clamp high and low
    repeat (5) cyc();
    send(63);
    chk("clamp_hi_flag", {7'd0, clamp_flag}, 8'd1);
    chk("clamp_hi_ready", {7'd0, req_ready}, 8'd0);
    settle();
    chk("clamp_hi_d", {2'b00, d_n_out}, 8'd58);
    repeat (5) cyc();
    send(0);
    chk("clamp_lo_flag", {7'd0, clamp_flag}, 8'd1);
    settle();
    chk("clamp_lo_d", {2'b00, d_n_out}, 8'd2);

    // Commit only at period boundary (slew-limited when the feature is on)
    send(20);
    settle();
    repeat (5) cyc();
    send(30);
    repeat (3) cyc();
    chk("hold_mid_d", {2'b00, d_n_out}, 8'd20);
    wait_sync();
`ifdef DUTY_SLEW_LIMIT_EN
    chk("slew1_d", {2'b00, d_n_out}, 8'd24);
    wait_sync();
    chk("slew2_d", {2'b00, d_n_out}, 8'd28);
    wait_sync();
    chk("slew3_d", {2'b00, d_n_out}, 8'd30);
`else
    chk("commit_d", {2'b00, d_n_out}, 8'd30);
`endif

    // Fault mid-period
    repeat (5) cyc();
    fault = 1'b1;
    cyc();
    chk("fault_state", {6'd0, state}, 8'd3);
    chk("fault_d", {2'b00, d_n_out}, 8'd0);
    chk("fault_ready", {7'd0, req_ready}, 8'd0);
    fault = 1'b0;
    repeat (3) cyc();
    chk("fault_hold_state", {6'd0, state}, 8'd3);
    en = 1'b0;
    cyc();
    chk("fault_exit_state", {6'd0, state}, 8'd0);

    // en deassert mid-period takes effect at sync
    en = 1'b1;
    wait_sync();
    wait_sync();
    send(30);
    settle();
    repeat (5) cyc();
    en = 1'b0;
    repeat (5) cyc();
    chk("en_off_hold_d", {2'b00, d_n_out}, 8'd30);
    wait_sync();
    chk("en_off_d", {2'b00, d_n_out}, 8'd0);
    chk("en_off_state", {6'd0, state}, 8'd0);

    // Reset mid-SOFT
    en = 1'b1;
    wait_sync();
    chk("pre_rst_state", {6'd0, state}, 8'd1);
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_state", {6'd0, state}, 8'd0);
    chk("midrst_d", {2'b00, d_n_out}, 8'd0);
    chk("midrst_ready", {7'd0, req_ready}, 8'd0);
    rst = 1'b0;

    // Randomized traffic against the model
    auto_sync = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 79) == 0) fault = ~fault;
      if ($urandom_range(0, 59) == 0) en = ~en;
      if (!(req_valid && !m_last_xfer)) begin
        req_valid = ($urandom_range(0, 2) == 0);
        req_duty  = 6'($urandom_range(0, 63));
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
